// File: rtl/eth_tx_arbiter_if.sv
// eth_tx_arbiter_if: one AXI-Stream channel (data, last, valid, ready) with
// master (source) and slave (sink) views.
interface eth_tx_arbiter_if #(
  parameter int DW = 512
) ();
  logic [DW-1:0] tdata;
  logic          tlast;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, output tlast, output tvalid, input  tready);
  modport slave  (input  tdata, input  tlast, input  tvalid, output tready);
endinterface

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: packet-boundary round-robin arbiter merging the host transmit and
// loopback AXI-Stream sources into one registered TX stream. Optional macro: ETH_TX_ARB_PKT_COUNT_EN.
module eth_tx_arbiter #(
  parameter int DW = 512
) (
  input  logic             clk,
  input  logic             resetn,
  eth_tx_arbiter_if.slave  axis_xmit,
  eth_tx_arbiter_if.slave  axis_loop,
  eth_tx_arbiter_if.master axis_out,
  output logic             active_port,
  output logic             busy,
  output logic [31:0]      xmit_pkt_count,
  output logic [31:0]      loop_pkt_count
);

  // Encoding chosen so busy and active_port are the state flop bits themselves.
  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    GRANT_XMIT = 2'b10,
    GRANT_LOOP = 2'b11
  } state_t;

  state_t        state_r, state_s;
  logic          last_grant_r, last_grant_s;
  logic          out_valid_r, out_last_r;
  logic [DW-1:0] out_data_r;
  logic          out_free_s;
  logic          xmit_ready_s, loop_ready_s;
  logic          xmit_acc_s, loop_acc_s;
  logic          load_s, load_last_s;
  logic [DW-1:0] load_data_s;

  assign out_free_s = !out_valid_r || axis_out.tready;
  assign xmit_acc_s = xmit_ready_s && axis_xmit.tvalid;
  assign loop_acc_s = loop_ready_s && axis_loop.tvalid;
  assign load_s     = xmit_acc_s || loop_acc_s;

  // State and last-grant registers; last_grant resets to loop so xmit wins the first tie
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
    end
  end

  // Arbitration in IDLE, grant release on an accepted tlast, input ready generation
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    xmit_ready_s = 1'b0;
    loop_ready_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (axis_xmit.tvalid && (!axis_loop.tvalid || last_grant_r)) begin
          state_s      = GRANT_XMIT;
          last_grant_s = 1'b0;
        end else if (axis_loop.tvalid) begin
          state_s      = GRANT_LOOP;
          last_grant_s = 1'b1;
        end else begin
          state_s      = IDLE;
        end
      end
      GRANT_XMIT: begin
        xmit_ready_s = out_free_s;
        if (out_free_s && axis_xmit.tvalid && axis_xmit.tlast) begin
          state_s = IDLE;
        end else begin
          state_s = GRANT_XMIT;
        end
      end
      GRANT_LOOP: begin
        loop_ready_s = out_free_s;
        if (out_free_s && axis_loop.tvalid && axis_loop.tlast) begin
          state_s = IDLE;
        end else begin
          state_s = GRANT_LOOP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Source mux feeding the output register
  always_comb begin
    if (loop_acc_s) begin
      load_data_s = axis_loop.tdata;
      load_last_s = axis_loop.tlast;
    end else begin
      load_data_s = axis_xmit.tdata;
      load_last_s = axis_xmit.tlast;
    end
  end

  // One-beat output register: load on accept, drop valid once consumed
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DW{1'b0}};
      out_last_r  <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= load_data_s;
      out_last_r  <= load_last_s;
    end else if (axis_out.tready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign axis_xmit.tready = xmit_ready_s;
  assign axis_loop.tready = loop_ready_s;
  assign axis_out.tvalid  = out_valid_r;
  assign axis_out.tdata   = out_data_r;
  assign axis_out.tlast   = out_last_r;
  assign busy             = state_r[1];
  assign active_port      = state_r[0];

`ifdef ETH_TX_ARB_PKT_COUNT_EN
  logic [31:0] xmit_cnt_r, loop_cnt_r;

  // Per-port packet counters, bumped on each accepted tlast, free-running wrap
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      xmit_cnt_r <= 32'd0;
      loop_cnt_r <= 32'd0;
    end else begin
      if (xmit_acc_s && axis_xmit.tlast) begin
        xmit_cnt_r <= xmit_cnt_r + 32'd1;
      end
      if (loop_acc_s && axis_loop.tlast) begin
        loop_cnt_r <= loop_cnt_r + 32'd1;
      end
    end
  end

  assign xmit_pkt_count = xmit_cnt_r;
  assign loop_pkt_count = loop_cnt_r;
`else
  assign xmit_pkt_count = 32'd0;
  assign loop_pkt_count = 32'd0;
`endif

endmodule

// File: doc/eth_tx_arbiter.md
# eth_tx_arbiter

Packet-boundary round-robin arbiter that shares the single Ethernet TX stream between the "axis_xmit" (host transmit) and "axis_loop" (loopback) AXI-Stream sources. It replaces static port selection: both sources are back-pressured rather than dropped, and ownership of the output changes only between packets. The output is registered, one beat deep, and sits directly in front of the Ethernet MAC TX interface.

## Interface
- DW, 512, tdata width in bits for all three streams.
- clk  in  1  single clock; all logic is rising-edge.
- resetn  in  1  asynchronous active-low reset.
- axis_xmit_tdata  in  DW  host transmit data.
- axis_xmit_tlast  in  1  last beat of packet.
- axis_xmit_tvalid  in  1  beat valid.
- axis_xmit_tready  out  1  beat accepted when high with tvalid.
- axis_loop_tdata / _tlast / _tvalid / _tready: same as axis_xmit_*, for the loopback source.
- axis_out_tdata  out  DW  registered output data.
- axis_out_tlast  out  1  registered tlast.
- axis_out_tvalid  out  1  registered valid.
- axis_out_tready  in  1  downstream ready.
- active_port  out  1  0 = xmit owns output, 1 = loop owns output; meaningful only when busy=1.
- busy  out  1  high while a packet is granted (not IDLE).
- xmit_pkt_count  out  32  packets accepted from axis_xmit.
- loop_pkt_count  out  32  packets accepted from axis_loop.

## Operation
- FSM states: IDLE, GRANT_XMIT, GRANT_LOOP.
- IDLE: no input tready. If exactly one tvalid is high, grant that port. If both are high, grant the port opposite to last_grant. If neither is high, stay in IDLE.
- Grant is a transition to the GRANT state on the next edge. last_grant updates to the granted port on the same edge.
- GRANT_x: granted tready = (!axis_out_tvalid || axis_out_tready). Non-granted tready = 0.
- An accepted granted beat loads the output register.
- An accepted beat with tlast=1 returns the FSM to IDLE on the same edge.
- Output register behaviour:
  - Loads on each accepted input beat.
  - axis_out_tvalid clears when axis_out_tready=1 and no new beat is loaded.
  - axis_out_tdata and axis_out_tlast hold while tvalid=1 and tready=0.
- The register is pass-through, so full throughput holds within a packet.
- No beat is ever dropped or interleaved across ports.
- busy = (state != IDLE).
- active_port = 1 in GRANT_LOOP, 0 otherwise.
- Counters increment by 1 on each accepted input beat with tlast=1, for the port that supplied it. They wrap from 0xFFFFFFFF to 0.

## Timing
- Reset values:
  - state = IDLE.
  - last_grant = loop, so xmit wins the first tie.
  - axis_out_tvalid = 0.
  - axis_out_tdata = 0.
  - axis_out_tlast = 0.
  - both tready = 0.
  - busy = 0.
  - active_port = 0.
  - both counters = 0.
- Latency: input accept edge N → beat visible on axis_out at cycle N+1.
- Arbitration overhead: one IDLE cycle per packet. A packet whose first beat is valid at cycle 0 (FSM in IDLE) has that beat accepted at cycle 1 at the earliest.
- Single-beat packet (tlast on first beat): GRANT lasts one cycle, then IDLE.
- Both valid, back-to-back packets: ownership strictly alternates xmit, loop, xmit, ...
- tvalid deasserts mid-packet: grant is held and the FSM waits indefinitely. No timeout.
- Reset asserted mid-packet: all outputs go to reset values immediately.
  - The partial packet is truncated: no tlast is emitted for it.
  - Upstream sources must be reset together with this block.
- Output stalled (tready=0, tvalid=1): granted tready=0 combinationally and the held output beat is stable.

## Configuration
- ETH_TX_ARB_PKT_COUNT_EN defined: the xmit_pkt_count and loop_pkt_count registers and their increment logic are built as specified.
- ETH_TX_ARB_PKT_COUNT_EN undefined: both count ports remain present and are tied to constant 0. No counter flops are inferred.
- Arbitration and datapath behaviour are identical in both builds.

## Test plan
- Post-reset tie:
  - Stimulus: xmit and loop each present a 3-beat packet at cycle 0, out_tready=1.
  - Required: xmit beats on axis_out at cycles 2–4, loop beats at cycles 6–8 (one idle cycle between), tlast on beats 4 and 8, active_port 0 then 1.
- Back-pressure:
  - Stimulus: 4-beat xmit packet with data 0x1..0x4; out_tready toggles 1,0,1,0.
  - Required: axis_out shows 0x1, 0x2, 0x3, 0x4 in order with none lost or duplicated; tdata stable whenever tvalid=1 and tready=0.
- No interleave:
  - Stimulus: xmit starts a 5-beat packet; loop asserts tvalid after beat 2.
  - Required: loop_tready stays 0 until xmit tlast is accepted; loop packet follows after one IDLE cycle.
- Reset mid-packet:
  - Stimulus: resetn low during beat 2 of a 4-beat packet.
  - Required: axis_out_tvalid=0, busy=0, counters=0 while resetn is low; after release, a fresh loop-only packet is granted to loop.
- Counters and wrap (ETH_TX_ARB_PKT_COUNT_EN defined):
  - Stimulus: force xmit_pkt_count to 0xFFFFFFFE, send 3 single-beat xmit packets.
  - Required: count reads 0xFFFFFFFF, 0, 1; loop_pkt_count unchanged.
  - Undefined build: both counts read 0 throughout.
- Alternation:
  - Stimulus: both ports continuously valid with 1-beat packets for 10 packets.
  - Required: output ports alternate strictly x,l,x,l...; each counter ends at 5.
